// File: rtl/shift_reg_univ_sync.sv
// Universal shift register with single-step load/shift/rotate and a
// multi-cycle shift-by-N run reported through a busy/done handshake.
module shift_reg_univ_sync #(
   parameter int             WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}},
   localparam int            AMT_W     = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROTL = 3'b100;
   localparam logic [2:0] M_ROTR = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   state_t           state_q;
   logic [2:0]       mode_q;
   logic [AMT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_q;
   logic             done_q;
   logic [2:0]       sout_mode;

   function automatic logic [WIDTH-1:0] shift_op(input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic             s_in,
                                                 input logic [WIDTH-1:0] ld);
      logic [WIDTH-1:0] r;
      case (m)
         M_LOAD:  r = ld;
         M_SHL:   r = {v[WIDTH-2:0], s_in};
         M_SHR:   r = {s_in, v[WIDTH-1:1]};
         M_ROTL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROTR:  r = {v[0], v[WIDTH-1:1]};
         M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic logic is_shift(input logic [2:0] m);
      return (m >= M_SHL) && (m <= M_ASR);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= 3'b000;
         cnt_q   <= '0;
         q_q     <= RESET_VAL;
         done_q  <= 1'b0;
      end else if (set) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= SET_VAL;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RUN: begin
               q_q   <= shift_op(mode_q, q_q, sin, d);
               cnt_q <= cnt_q - AMT_W'(1);
               if (cnt_q == AMT_W'(1)) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  if (is_shift(mode)) begin
                     // A zero-length run completes immediately without going busy
                     if (amt != '0) begin
                        mode_q  <= mode;
                        cnt_q   <= amt;
                        state_q <= RUN;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end else begin
                     q_q <= shift_op(mode, q_q, sin, d);
                  end
               end else if (en) begin
                  q_q <= shift_op(mode, q_q, sin, d);
               end
            end
         endcase
      end
   end

   assign sout_mode = (state_q == RUN) ? mode_q : mode;
   assign sout      = (sout_mode == M_SHL || sout_mode == M_ROTL) ? q_q[WIDTH-1] : q_q[0];
   assign q         = q_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

endmodule
